ioctl_load_manager: RTL and testbench
=====================================

Name: ioctl_load_manager

Overview:
- Parametrised successor to the inline DIP-capture and download-gating logic in arcade top levels.
- Sits between hps_io's ioctl bus and the game core.
- Routes ROM bytes to the core with a registered write strobe and bounds checking.
- Captures a configurable number of DIP bytes, generates a stretched core reset, and reports load status: byte count, checksum, overflow.

Parameters:
- ROM_INDEX, 0, ioctl_index value carrying ROM data
- DIP_INDEX, 254, ioctl_index value carrying DIP bytes
- NUM_DIP, 8, number of DIP bytes captured (1..32)
- ADDR_W, 16, width of dn_addr to core
- ROM_SIZE, 65536, bytes accepted for ROM index; writes at or above are dropped
- RESET_HOLD, 16, CLK cycles core_reset is held after any reset source deasserts (≥1)

Ports:
- CLK  in  1  system clock (clk_sys)
- RESET  in  1  synchronous active-high reset; clears all state
- ext_reset  in  1  soft reset request (menu/button); does not clear DIPs or status
- ioctl_download  in  1  download active
- ioctl_index  in  8  download index
- ioctl_wr  in  1  byte write strobe, one cycle per byte
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  ADDR_W  registered ROM address to core
- dn_data  out  8  registered ROM data
- dn_wr  out  1  one-cycle ROM write strobe
- dn_ld  out  1  high while a ROM_INDEX download is active
- dip_sw  out  8*NUM_DIP  DIP bytes; byte k at [8k+7:8k]
- core_reset  out  1  reset to game core
- rom_loaded  out  1  last ROM download completed without overflow
- dn_count  out  25  ROM bytes accepted in current/last ROM download
- dn_sum  out  8  mod-256 sum of accepted ROM bytes
- dn_overflow  out  1  a ROM write at addr ≥ ROM_SIZE was dropped

Behaviour:
- Reset values (RESET=1): dn_addr=0, dn_data=0, dn_wr=0, dn_ld=0, dip_sw=0, core_reset=1, rom_loaded=0, dn_count=0, dn_sum=0, dn_overflow=0. State=IDLE, hold counter=RESET_HOLD.
- FSM states:
  - IDLE→LOAD_ROM on ioctl_download=1 with index=ROM_INDEX.
  - IDLE→LOAD_OTHER on ioctl_download=1 with any other index.
  - LOAD_ROM→IDLE on ioctl_download falling edge.
  - LOAD_OTHER→IDLE on ioctl_download falling edge.
  - Index is sampled only on the IDLE exit; changes mid-download are ignored.
- Entering LOAD_ROM: dn_count, dn_sum, dn_overflow and rom_loaded clear in the same cycle. dn_ld=1 registered, i.e. high from the cycle after download rises, low the cycle after it falls.
- ROM write, in LOAD_ROM with ioctl_wr=1:
  - If ioctl_addr < ROM_SIZE: next cycle dn_wr=1, dn_addr=ioctl_addr[ADDR_W-1:0], dn_data=ioctl_dout (latency 1). dn_count increments by 1 (saturates at 2^25-1). dn_sum += data mod 256.
  - Otherwise: no dn_wr, dn_overflow set (sticky until next ROM download or RESET).
  - dn_addr/dn_data hold their values between strobes.
- DIP write, in LOAD_OTHER with index=DIP_INDEX and ioctl_wr=1: if ioctl_addr < NUM_DIP, dip_sw byte[ioctl_addr] = ioctl_dout next cycle; else ignored. Other indices are ignored entirely.
- LOAD_ROM→IDLE transition: rom_loaded = ~dn_overflow, evaluated including a dropped write in the final cycle.
- Reset source, raw = ext_reset | (state==LOAD_ROM) | ioctl_download-with-ROM_INDEX.
  - While raw=1: core_reset=1 and hold counter reloads to RESET_HOLD.
  - After raw falls: counter decrements each cycle; core_reset deasserts the cycle the counter reaches 0, i.e. exactly RESET_HOLD cycles after the last raw=1 cycle.
  - DIP/other downloads do not reset the core.
- Simultaneous events:
  - RESET dominates everything.
  - ext_reset during a download does not disturb data capture.
  - ioctl_wr in the same cycle download falls is still processed against the current state.
- ioctl_wr with ioctl_download=0 is ignored.

Test Plan:
- Power-on: RESET 3 cycles then release, no other activity → core_reset low exactly 16 cycles after RESET falls; all other outputs 0.
- ROM load: index 0, write bytes 0x01,0x02,0xFF at addr 0,1,2 → three dn_wr pulses each 1 cycle after ioctl_wr with matching addr/data; dn_count=3, dn_sum=0x02, rom_loaded=1 after download falls; core_reset low 16 cycles later.
- Overflow: ROM_SIZE=4, writes at addr 3 and 4 → one dn_wr (addr 3) only; dn_overflow=1; rom_loaded=0 at end; next clean ROM download clears dn_overflow and sets rom_loaded=1.
- DIPs: index 254, write 0xA5@0, 0x3C@7, 0x77@8 → dip_sw byte0=0xA5, byte7=0x3C, 0x77 discarded; no dn_wr; core_reset unaffected.
- Soft reset: ext_reset pulse 1 cycle after load → core_reset high, falls 16 cycles after pulse; dip_sw, dn_count, rom_loaded unchanged. RESET asserted mid-ROM-download → all outputs at reset values next cycle; FSM stays IDLE until ioctl_download next rises (ongoing download ignored).
- Index change mid-download: ROM download starts, ioctl_index switched to 254 while writing → writes still routed to dn_wr, dip_sw unchanged.

Source files
------------

// File: rtl/ioctl_load_manager.sv
// Routes hps_io ioctl bytes to the ROM port / DIP bank, stretches core reset, tracks load status.
// Latency: ROM and DIP writes land one cycle after ioctl_wr; no backpressure, every strobe is taken or dropped.
module ioctl_load_manager #(
    parameter int ROM_INDEX  = 0,
    parameter int DIP_INDEX  = 254,
    parameter int NUM_DIP    = 8,
    parameter int ADDR_W     = 16,
    parameter int ROM_SIZE   = 65536,
    parameter int RESET_HOLD = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ext_reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [ADDR_W-1:0]      dn_addr,
    output logic [7:0]             dn_data,
    output logic                   dn_wr,
    output logic                   dn_ld,
    output logic [8*NUM_DIP-1:0]   dip_sw,
    output logic                   core_reset,
    output logic                   rom_loaded,
    output logic [24:0]            dn_count,
    output logic [7:0]             dn_sum,
    output logic                   dn_overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROM   = 2'd1;
    localparam logic [1:0] ST_OTHER = 2'd2;

    localparam int              HOLD_W   = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_VAL = HOLD_W'(RESET_HOLD);
    localparam logic [7:0]      ROM_IDX  = ROM_INDEX[7:0];
    localparam logic [7:0]      DIP_IDX  = DIP_INDEX[7:0];
    localparam logic [25:0]     ROM_LIM  = 26'(ROM_SIZE);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              dl_prev;
    logic              is_dip;
    logic [HOLD_W-1:0] hold_cnt;

    logic dl_rise;
    logic idx_rom;
    logic idx_dip;
    logic rom_wr;
    logic rom_ok;
    logic rom_drop;
    logic dip_wr;
    logic enter_rom;
    logic leave_rom;
    logic raw_reset;

    // Downloads start only on a rising edge, so one still in progress across RESET is ignored.
    assign dl_rise   = ioctl_download & ~dl_prev;
    assign idx_rom   = (ioctl_index == ROM_IDX);
    assign idx_dip   = (ioctl_index == DIP_IDX);
    assign rom_wr    = (state == ST_ROM) & ioctl_wr;
    assign rom_ok    = rom_wr & ({1'b0, ioctl_addr} < ROM_LIM);
    assign rom_drop  = rom_wr & ~rom_ok;
    assign dip_wr    = (state == ST_OTHER) & is_dip & ioctl_wr;
    assign enter_rom = (state == ST_IDLE) & dl_rise & idx_rom;
    assign leave_rom = (state == ST_ROM) & ~ioctl_download;
    assign raw_reset = ext_reset | (state == ST_ROM) | (ioctl_download & idx_rom);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dl_rise) begin
                    state_nxt = idx_rom ? ST_ROM : ST_OTHER;
                end
            end
            ST_ROM, ST_OTHER: begin
                if (!ioctl_download) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        dl_prev <= ioctl_download;
        if (RESET) begin
            state       <= ST_IDLE;
            is_dip      <= 1'b0;
            dn_addr     <= '0;
            dn_data     <= '0;
            dn_wr       <= 1'b0;
            dn_ld       <= 1'b0;
            dip_sw      <= '0;
            rom_loaded  <= 1'b0;
            dn_count    <= '0;
            dn_sum      <= '0;
            dn_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            dn_ld <= (state_nxt == ST_ROM);
            dn_wr <= rom_ok;

            if ((state == ST_IDLE) && dl_rise) begin
                is_dip <= idx_dip;
            end

            if (rom_ok) begin
                dn_addr <= ioctl_addr[ADDR_W-1:0];
                dn_data <= ioctl_dout;
            end

            if (enter_rom) begin
                dn_count    <= '0;
                dn_sum      <= '0;
                dn_overflow <= 1'b0;
                rom_loaded  <= 1'b0;
            end else begin
                if (rom_ok) begin
                    if (dn_count != '1) begin
                        dn_count <= dn_count + 25'd1;
                    end
                    dn_sum <= dn_sum + ioctl_dout;
                end
                if (rom_drop) begin
                    dn_overflow <= 1'b1;
                end
                // A byte dropped in the very cycle the download ends still spoils the load.
                if (leave_rom) begin
                    rom_loaded <= ~(dn_overflow | rom_drop);
                end
            end

            for (int k = 0; k < NUM_DIP; k++) begin
                if (dip_wr && (ioctl_addr == 25'(k))) begin
                    dip_sw[8*k +: 8] <= ioctl_dout;
                end
            end
        end
    end

    // core_reset drops exactly RESET_HOLD cycles after the last cycle any source was active.
    always_ff @(posedge CLK) begin
        if (RESET || raw_reset) begin
            hold_cnt   <= HOLD_VAL;
            core_reset <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt   <= hold_cnt - 1'b1;
            core_reset <= (hold_cnt != HOLD_W'(1));
        end else begin
            core_reset <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ioctl_load_manager.sv
// Bench: table-driven ROM/DIP vectors, hand-written corner sequences and a randomized run,
// all compared every cycle against a behavioural model for a default and a ROM_SIZE=4 instance.
module tb_ioctl_load_manager;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ext, dl, wr;
    logic [7:0]  idx, dout;
    logic [24:0] addr;

    logic [15:0] dn_addr_a, dn_addr_b;
    logic [7:0]  dn_data_a, dn_data_b, dn_sum_a, dn_sum_b;
    logic        dn_wr_a, dn_wr_b, dn_ld_a, dn_ld_b, cr_a, cr_b;
    logic        loaded_a, loaded_b, ovf_a, ovf_b;
    logic [63:0] dip_a, dip_b;
    logic [24:0] cnt_a, cnt_b;

    ioctl_load_manager u_big (
        .CLK(clk), .RESET(rst), .ext_reset(ext), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout),
        .dn_addr(dn_addr_a), .dn_data(dn_data_a), .dn_wr(dn_wr_a), .dn_ld(dn_ld_a),
        .dip_sw(dip_a), .core_reset(cr_a), .rom_loaded(loaded_a), .dn_count(cnt_a),
        .dn_sum(dn_sum_a), .dn_overflow(ovf_a)
    );

    ioctl_load_manager #(.ROM_SIZE(4)) u_small (
        .CLK(clk), .RESET(rst), .ext_reset(ext), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout),
        .dn_addr(dn_addr_b), .dn_data(dn_data_b), .dn_wr(dn_wr_b), .dn_ld(dn_ld_b),
        .dip_sw(dip_b), .core_reset(cr_b), .rom_loaded(loaded_b), .dn_count(cnt_b),
        .dn_sum(dn_sum_b), .dn_overflow(ovf_b)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = default, 1 = ROM_SIZE 4) ----------------
    bit          m_rom [2];
    bit          m_oth [2];
    bit          m_dipdl [2];
    bit          m_dlp [2];
    bit          m_wr [2];
    bit          m_loaded [2];
    bit          m_ovf [2];
    logic [15:0] m_a [2];
    logic [7:0]  m_d [2];
    logic [24:0] m_cnt [2];
    logic [7:0]  m_sum [2];
    logic [7:0]  m_dip [2][8];
    int          m_since [2];

    task automatic model_step(input int i, input int rom_size);
        bit raw;
        if (rst) begin
            m_rom[i] = 0; m_oth[i] = 0; m_dipdl[i] = 0; m_wr[i] = 0; m_loaded[i] = 0;
            m_ovf[i] = 0; m_a[i] = 0; m_d[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
            for (int k = 0; k < 8; k++) m_dip[i][k] = 8'h00;
            m_since[i] = 0;
        end else begin
            raw = ext || m_rom[i] || (dl && idx == 8'd0);
            m_wr[i] = 0;
            if (m_rom[i] && wr) begin
                if (int'(addr) < rom_size) begin
                    m_wr[i] = 1;
                    m_a[i] = addr[15:0];
                    m_d[i] = dout;
                    if (m_cnt[i] != 25'h1FFFFFF) m_cnt[i] = m_cnt[i] + 25'd1;
                    m_sum[i] = m_sum[i] + dout;
                end else begin
                    m_ovf[i] = 1;
                end
            end
            if (m_oth[i] && m_dipdl[i] && wr && int'(addr) < 8) m_dip[i][addr[2:0]] = dout;
            if (m_rom[i] && !dl) begin
                m_rom[i] = 0;
                m_loaded[i] = !m_ovf[i];
            end else if (m_oth[i] && !dl) begin
                m_oth[i] = 0;
            end else if (!m_rom[i] && !m_oth[i] && dl && !m_dlp[i]) begin
                if (idx == 8'd0) begin
                    m_rom[i] = 1; m_cnt[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_loaded[i] = 0;
                end else begin
                    m_oth[i] = 1;
                    m_dipdl[i] = (idx == 8'd254);
                end
            end
            m_since[i] = raw ? 0 : ((m_since[i] < 1000) ? m_since[i] + 1 : 1000);
        end
        m_dlp[i] = dl;
    endtask

    function automatic logic [63:0] dip_exp(input int i);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = m_dip[i][k];
        return r;
    endfunction

    task automatic chk_dut(input int i, input logic w, input logic [15:0] a_, input logic [7:0] d_,
                           input logic ld_, input logic [63:0] dip_, input logic cr_,
                           input logic lo_, input logic [24:0] cnt_, input logic [7:0] sum_,
                           input logic ovf_);
        string p;
        p = (i == 0) ? "big" : "small";
        chk({p, ".dn_wr"}, w, m_wr[i]);
        chk({p, ".dn_addr"}, a_, m_a[i]);
        chk({p, ".dn_data"}, d_, m_d[i]);
        chk({p, ".dn_ld"}, ld_, m_rom[i]);
        chk({p, ".dip_sw"}, dip_, dip_exp(i));
        chk({p, ".core_reset"}, cr_, m_since[i] < 16);
        chk({p, ".rom_loaded"}, lo_, m_loaded[i]);
        chk({p, ".dn_count"}, cnt_, m_cnt[i]);
        chk({p, ".dn_sum"}, sum_, m_sum[i]);
        chk({p, ".dn_overflow"}, ovf_, m_ovf[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 65536);
        model_step(1, 4);
        #1;
        chk_dut(0, dn_wr_a, dn_addr_a, dn_data_a, dn_ld_a, dip_a, cr_a, loaded_a, cnt_a, dn_sum_a, ovf_a);
        chk_dut(1, dn_wr_b, dn_addr_b, dn_data_b, dn_ld_b, dip_b, cr_b, loaded_b, cnt_b, dn_sum_b, ovf_b);
    endtask

    task automatic drive(input logic e, input logic d, input logic [7:0] ix, input logic w,
                         input logic [24:0] ad, input logic [7:0] dt);
        ext = e; dl = d; idx = ix; wr = w; addr = ad; dout = dt;
    endtask

    // Counts edges until core_reset drops; called right after the last reset-source cycle.
    task automatic measure(input string name, input int expect_n);
        int n = 0;
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00);
        while (cr_a === 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        chk({name, ".release_cycles"}, 64'(n), 64'(expect_n));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ext;
        logic        dl;
        logic [7:0]  idx;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_ld;
        logic [24:0] e_cnt;
        logic [7:0]  e_sum;
        logic        e_loaded;
        logic        e_cr;
        logic [7:0]  e_dip0;
        logic [7:0]  e_dip7;
    } vec_t;

    vec_t tbl[$];

    task automatic apply_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            drive(tbl[r].ext, tbl[r].dl, tbl[r].idx, tbl[r].wr, tbl[r].addr, tbl[r].dout);
            cycle();
            chk($sformatf("row%0d.dn_wr", r), dn_wr_a, tbl[r].e_wr);
            chk($sformatf("row%0d.dn_addr", r), dn_addr_a, tbl[r].e_addr);
            chk($sformatf("row%0d.dn_data", r), dn_data_a, tbl[r].e_data);
            chk($sformatf("row%0d.dn_ld", r), dn_ld_a, tbl[r].e_ld);
            chk($sformatf("row%0d.dn_count", r), cnt_a, tbl[r].e_cnt);
            chk($sformatf("row%0d.dn_sum", r), dn_sum_a, tbl[r].e_sum);
            chk($sformatf("row%0d.rom_loaded", r), loaded_a, tbl[r].e_loaded);
            chk($sformatf("row%0d.core_reset", r), cr_a, tbl[r].e_cr);
            chk($sformatf("row%0d.dip0", r), dip_a[7:0], tbl[r].e_dip0);
            chk($sformatf("row%0d.dip7", r), dip_a[63:56], tbl[r].e_dip7);
        end
    endtask

    initial begin
        // ROM load: bytes 01,02,FF at 0,1,2 (rows 0-5)
        tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 16'd0, 8'h00, 1'b1, 25'd0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b1, 25'd0, 8'h01, 1'b1, 16'd0, 8'h01, 1'b1, 25'd1, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 16'd0, 8'h01, 1'b1, 25'd1, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b1, 25'd1, 8'h02, 1'b1, 16'd1, 8'h02, 1'b1, 25'd2, 8'h03, 1'b0, 1'b1, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd0, 1'b1, 25'd2, 8'hFF, 1'b1, 16'd2, 8'hFF, 1'b1, 25'd3, 8'h02, 1'b0, 1'b1, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b1, 8'h00, 8'h00});
        // DIP load: A5@0, 3C@7, 77@8 discarded (rows 6-10)
        tbl.push_back('{1'b0, 1'b1, 8'd254, 1'b0, 25'd0, 8'h00, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd254, 1'b1, 25'd0, 8'hA5, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b0, 8'hA5, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'd254, 1'b1, 25'd7, 8'h3C, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b0, 8'hA5, 8'h3C});
        tbl.push_back('{1'b0, 1'b1, 8'd254, 1'b1, 25'd8, 8'h77, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b0, 8'hA5, 8'h3C});
        tbl.push_back('{1'b0, 1'b0, 8'd254, 1'b0, 25'd0, 8'h00, 1'b0, 16'd2, 8'hFF, 1'b0, 25'd3, 8'h02, 1'b1, 1'b0, 8'hA5, 8'h3C});

        // Power-on
        rst = 1'b1;
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00);
        repeat (3) cycle();
        chk("reset.core_reset", cr_a, 1'b1);
        chk("reset.dn_ld", dn_ld_a, 1'b0);
        chk("reset.dip_sw", dip_a, 64'h0);
        chk("reset.dn_count", cnt_a, 25'd0);
        rst = 1'b0;
        measure("poweron", 16);
        chk("poweron.dn_wr", dn_wr_a, 1'b0);
        chk("poweron.rom_loaded", loaded_a, 1'b0);

        apply_rows(0, 5);
        measure("romload", 16);
        apply_rows(6, 10);
        chk("dip.full", dip_a, 64'h3C000000000000A5);

        // Soft reset does not touch DIPs or load status
        drive(1, 0, 8'd0, 0, 25'd0, 8'h00);
        cycle();
        chk("ext.core_reset", cr_a, 1'b1);
        measure("ext", 16);
        chk("ext.dip0", dip_a[7:0], 8'hA5);
        chk("ext.dn_count", cnt_a, 25'd3);
        chk("ext.rom_loaded", loaded_a, 1'b1);

        // Overflow on the ROM_SIZE=4 instance
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 1, 8'd0, 1, 25'd3, 8'h11); cycle();
        chk("ovf.small_wr3", dn_wr_b, 1'b1);
        chk("ovf.small_addr3", dn_addr_b, 16'd3);
        drive(0, 1, 8'd0, 1, 25'd4, 8'h22); cycle();
        chk("ovf.small_wr4", dn_wr_b, 1'b0);
        chk("ovf.small_flag", ovf_b, 1'b1);
        chk("ovf.big_wr4", dn_wr_a, 1'b1);
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();
        chk("ovf.small_loaded", loaded_b, 1'b0);
        chk("ovf.small_count", cnt_b, 25'd1);
        chk("ovf.small_sum", dn_sum_b, 8'h11);
        chk("ovf.big_loaded", loaded_a, 1'b1);
        // Dropped write in the same cycle the download falls
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 0, 8'd0, 1, 25'd6, 8'h33); cycle();
        chk("lastdrop.small_loaded", loaded_b, 1'b0);
        chk("lastdrop.small_ovf", ovf_b, 1'b1);
        chk("lastdrop.big_wr", dn_wr_a, 1'b1);
        chk("lastdrop.big_loaded", loaded_a, 1'b1);
        // Clean download clears overflow
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        chk("clean.small_ovf_cleared", ovf_b, 1'b0);
        drive(0, 1, 8'd0, 1, 25'd0, 8'h05); cycle();
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();
        chk("clean.small_loaded", loaded_b, 1'b1);
        chk("clean.small_ovf", ovf_b, 1'b0);
        repeat (20) cycle();

        // Index switched to DIP mid ROM download
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 1, 8'd254, 1, 25'd1, 8'h66); cycle();
        chk("idxchg.dn_wr", dn_wr_a, 1'b1);
        chk("idxchg.dn_data", dn_data_a, 8'h66);
        drive(0, 1, 8'd254, 1, 25'd0, 8'h99); cycle();
        chk("idxchg.dip", dip_a, 64'h3C000000000000A5);
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();

        // RESET in the middle of a ROM download
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 1, 8'd0, 1, 25'd0, 8'h44); cycle();
        rst = 1'b1;
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        chk("midrst.dn_addr", dn_addr_a, 16'd0);
        chk("midrst.dn_data", dn_data_a, 8'h00);
        chk("midrst.dip_sw", dip_a, 64'h0);
        chk("midrst.dn_ld", dn_ld_a, 1'b0);
        chk("midrst.core_reset", cr_a, 1'b1);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(0, 1, 8'd0, 1, 25'(j), 8'h55); cycle();
            chk("midrst.ignored_wr", dn_wr_a, 1'b0);
            chk("midrst.ignored_ld", dn_ld_a, 1'b0);
        end
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();
        drive(0, 1, 8'd0, 0, 25'd0, 8'h00); cycle();
        chk("midrst.restart_ld", dn_ld_a, 1'b1);
        drive(0, 0, 8'd0, 0, 25'd0, 8'h00); cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] nidx;
            rst  = ($urandom_range(0, 299) == 0);
            ext  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) dl = ~dl;
            case ($urandom_range(0, 3))
                0, 1:    nidx = 8'd0;
                2:       nidx = 8'd254;
                default: nidx = 8'd5;
            endcase
            if (!dl || $urandom_range(0, 49) == 0) idx = nidx;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) != 0) ? 25'($urandom_range(0, 9)) : 25'($urandom);
            dout = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
